// File: rtl/midi_stream_parser_if.sv
// Byte-event bus between the UART receiver, the MIDI stream parser and midi_in_mux.
// The slave side is the parser: it consumes rx_* and produces the per-byte event fields.
interface midi_stream_parser_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_frame_err;
  logic       byteready;
  logic [7:0] cur_status;
  logic [7:0] midibyte_nr;
  logic [7:0] midi_in_data;

  modport master (
    output rx_valid, rx_data, rx_frame_err,
    input  byteready, cur_status, midibyte_nr, midi_in_data
  );

  modport slave (
    input  rx_valid, rx_data, rx_frame_err,
    output byteready, cur_status, midibyte_nr, midi_in_data
  );
endinterface

// File: rtl/midi_stream_parser.sv
// MIDI stream parser: frames raw UART bytes into byteready/cur_status/midibyte_nr events.
// Optional active-sense timeout with all-notes-off emission when MIDI_ACTIVE_SENSE_EN is defined.
module midi_stream_parser #(
  parameter int unsigned AS_TIMEOUT_CYC = 15_000_000
) (
  input  logic                CLOCK_50,
  input  logic                reset_reg_N,
  midi_stream_parser_if.slave bus,
  output logic [7:0]          parse_err_cnt,
  output logic                as_timeout
);

`ifdef MIDI_ACTIVE_SENSE_EN
  typedef enum logic [2:0] {S_IDLE, S_CHAN, S_SYSEX, S_SKIP, S_EMIT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_CHAN, S_SYSEX, S_SKIP} state_t;
`endif

  state_t     state, state_nxt;
  logic [7:0] cur_q, cur_nxt;
  logic [7:0] nr_q, nr_nxt;
  logic [7:0] data_q, data_nxt;
  logic       rdy_q, rdy_nxt;
  logic       clr_q, clr_nxt;
  logic       err_inc;
  logic       proc_valid;
  logic       proc_ferr;
  logic [7:0] proc_byte;
  logic [7:0] data_len;

`ifdef MIDI_ACTIVE_SENSE_EN
  logic [31:0] as_cnt_q, as_cnt_nxt;
  logic        armed_q, armed_nxt;
  logic        asto_q, asto_nxt;
  logic [2:0]  step_q, step_nxt;
  logic [3:0]  ch_q, ch_nxt;
  logic        skid_full_q, skid_full_nxt;
  logic [7:0]  skid_byte_q, skid_byte_nxt;
  logic        skid_ferr_q, skid_ferr_nxt;

  // A byte parked during emission is parsed before any newly arriving one.
  assign proc_valid = (state != S_EMIT) && (skid_full_q || bus.rx_valid);
  assign proc_byte  = skid_full_q ? skid_byte_q : bus.rx_data;
  assign proc_ferr  = skid_full_q ? skid_ferr_q : bus.rx_frame_err;
  assign as_timeout = asto_q;
`else
  assign proc_valid = bus.rx_valid;
  assign proc_byte  = bus.rx_data;
  assign proc_ferr  = bus.rx_frame_err;
  assign as_timeout = 1'b0;
`endif

  assign data_len = (cur_q[7:4] == 4'hC || cur_q[7:4] == 4'hD) ? 8'd1 : 8'd2;

  always_comb begin
    state_nxt = state;
    cur_nxt   = clr_q ? '0 : cur_q;
    nr_nxt    = nr_q;
    data_nxt  = data_q;
    rdy_nxt   = 1'b0;
    clr_nxt   = 1'b0;
    err_inc   = 1'b0;
`ifdef MIDI_ACTIVE_SENSE_EN
    ch_nxt        = ch_q;
    armed_nxt     = armed_q;
    as_cnt_nxt    = bus.rx_valid ? AS_TIMEOUT_CYC : (armed_q ? as_cnt_q - 32'd1 : as_cnt_q);
    asto_nxt      = 1'b0;
    step_nxt      = step_q;
    skid_full_nxt = skid_full_q;
    skid_byte_nxt = skid_byte_q;
    skid_ferr_nxt = skid_ferr_q;

    if (state == S_EMIT) begin
      if (bus.rx_valid) begin
        if (!skid_full_q) begin
          skid_full_nxt = 1'b1;
          skid_byte_nxt = bus.rx_data;
          skid_ferr_nxt = bus.rx_frame_err;
        end else begin
          err_inc = 1'b1;
        end
      end
      step_nxt = step_q + 3'd1;
      case (step_q)
        3'd0: begin
          rdy_nxt = 1'b1; data_nxt = {4'hB, ch_q}; nr_nxt = 8'd0; cur_nxt = {4'hB, ch_q};
        end
        3'd2: begin
          rdy_nxt = 1'b1; data_nxt = 8'h7B; nr_nxt = 8'd1; cur_nxt = {4'hB, ch_q};
        end
        3'd4: begin
          rdy_nxt = 1'b1; data_nxt = 8'h00; nr_nxt = 8'd2; cur_nxt = {4'hB, ch_q};
        end
        3'd5: begin
          state_nxt = S_IDLE; cur_nxt = '0; step_nxt = '0;
        end
        default: cur_nxt = {4'hB, ch_q};
      endcase
    end else if (skid_full_q) begin
      skid_full_nxt = bus.rx_valid;
      skid_byte_nxt = bus.rx_data;
      skid_ferr_nxt = bus.rx_frame_err;
    end

    if (armed_q && !bus.rx_valid && as_cnt_q == 32'd1 && state != S_EMIT) begin
      asto_nxt  = 1'b1;
      state_nxt = S_EMIT;
      step_nxt  = '0;
      armed_nxt = 1'b0;
    end
`endif

    if (proc_valid) begin
      if (proc_ferr) begin
        err_inc   = 1'b1;
        cur_nxt   = '0;
        state_nxt = S_IDLE;
      end else if (proc_byte >= 8'hF8) begin
`ifdef MIDI_ACTIVE_SENSE_EN
        if (proc_byte == 8'hFE) begin
          armed_nxt  = 1'b1;
          as_cnt_nxt = AS_TIMEOUT_CYC;
        end
`endif
      end else if (proc_byte[7]) begin
        // Any status other than EOX aborts an open sysex without an EOX pulse.
        if (state == S_SYSEX && proc_byte != 8'hF7) err_inc = 1'b1;
        if (proc_byte == 8'hF0) begin
          cur_nxt = 8'hF0; nr_nxt = '0; data_nxt = proc_byte; rdy_nxt = 1'b1;
          state_nxt = S_SYSEX;
        end else if (proc_byte == 8'hF7) begin
          if (state == S_SYSEX) begin
            nr_nxt    = (nr_q == 8'hFF) ? nr_q : nr_q + 8'd1;
            data_nxt  = proc_byte;
            rdy_nxt   = 1'b1;
            clr_nxt   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            err_inc = 1'b1;
          end
        end else if (proc_byte >= 8'hF1) begin
          cur_nxt   = '0;
          state_nxt = S_SKIP;
        end else begin
          cur_nxt = proc_byte; nr_nxt = '0; data_nxt = proc_byte; rdy_nxt = 1'b1;
          state_nxt = S_CHAN;
`ifdef MIDI_ACTIVE_SENSE_EN
          ch_nxt = proc_byte[3:0];
`endif
        end
      end else begin
        case (state)
          S_CHAN: begin
            nr_nxt   = (nr_q >= data_len) ? 8'd1 : nr_q + 8'd1;
            data_nxt = proc_byte;
            rdy_nxt  = 1'b1;
          end
          S_SYSEX: begin
            nr_nxt   = (nr_q == 8'hFF) ? nr_q : nr_q + 8'd1;
            data_nxt = proc_byte;
            rdy_nxt  = 1'b1;
          end
          S_SKIP:  ;
          default: err_inc = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state         <= S_IDLE;
      cur_q         <= '0;
      nr_q          <= '0;
      data_q        <= '0;
      rdy_q         <= 1'b0;
      clr_q         <= 1'b0;
      parse_err_cnt <= '0;
    end else begin
      state  <= state_nxt;
      cur_q  <= cur_nxt;
      nr_q   <= nr_nxt;
      data_q <= data_nxt;
      rdy_q  <= rdy_nxt;
      clr_q  <= clr_nxt;
      if (err_inc && parse_err_cnt != 8'hFF) parse_err_cnt <= parse_err_cnt + 8'd1;
    end
  end

`ifdef MIDI_ACTIVE_SENSE_EN
  always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      as_cnt_q    <= '0;
      armed_q     <= 1'b0;
      asto_q      <= 1'b0;
      step_q      <= '0;
      ch_q        <= '0;
      skid_full_q <= 1'b0;
      skid_byte_q <= '0;
      skid_ferr_q <= 1'b0;
    end else begin
      as_cnt_q    <= as_cnt_nxt;
      armed_q     <= armed_nxt;
      asto_q      <= asto_nxt;
      step_q      <= step_nxt;
      ch_q        <= ch_nxt;
      skid_full_q <= skid_full_nxt;
      skid_byte_q <= skid_byte_nxt;
      skid_ferr_q <= skid_ferr_nxt;
    end
  end
`endif

  assign bus.byteready    = rdy_q;
  assign bus.cur_status   = cur_q;
  assign bus.midibyte_nr  = nr_q;
  assign bus.midi_in_data = data_q;

endmodule

// File: tb/tb_midi_stream_parser.sv
// Directed-vector bench for midi_stream_parser; the active-sense scenario runs only
// when MIDI_ACTIVE_SENSE_EN is defined.
module tb_midi_stream_parser;
  logic       CLOCK_50 = 1'b0;
  logic       reset_reg_N;
  logic [7:0] parse_err_cnt;
  logic       as_timeout;
  int         total = 0;
  int         bad = 0;

  midi_stream_parser_if bus();

  midi_stream_parser #(.AS_TIMEOUT_CYC(40)) dut (
    .CLOCK_50     (CLOCK_50),
    .reset_reg_N  (reset_reg_N),
    .bus          (bus),
    .parse_err_cnt(parse_err_cnt),
    .as_timeout   (as_timeout)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic do_reset();
    reset_reg_N      = 1'b0;
    bus.rx_valid     = 1'b0;
    bus.rx_data      = 8'h00;
    bus.rx_frame_err = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    reset_reg_N = 1'b1;
    @(negedge CLOCK_50);
  endtask

  // One-cycle rx strobe; rdy is byteready one cycle later, when the event fields are valid.
  task automatic send(input logic [7:0] b, input logic ferr, output logic rdy);
    @(negedge CLOCK_50);
    bus.rx_valid     = 1'b1;
    bus.rx_data      = b;
    bus.rx_frame_err = ferr;
    @(negedge CLOCK_50);
    bus.rx_valid     = 1'b0;
    bus.rx_frame_err = 1'b0;
    rdy = bus.byteready;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.byteready !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b want=0", bus.byteready); end
    total++; if (bus.cur_status !== 8'h00) begin bad++; $display("FAIL reset_cur got=%h want=00", bus.cur_status); end
    total++; if (bus.midibyte_nr !== 8'h00) begin bad++; $display("FAIL reset_nr got=%h want=00", bus.midibyte_nr); end
    total++; if (bus.midi_in_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", bus.midi_in_data); end
    total++; if (parse_err_cnt !== 8'h00) begin bad++; $display("FAIL reset_err got=%h want=00", parse_err_cnt); end
    total++; if (as_timeout !== 1'b0) begin bad++; $display("FAIL reset_asto got=%b want=0", as_timeout); end
  endtask

  task automatic test_note_on();
    logic [7:0] bs [3];
    logic [7:0] nrs [3];
    logic r;
    bs  = '{8'h90, 8'h3C, 8'h64};
    nrs = '{8'd0, 8'd1, 8'd2};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(bs[i], 1'b0, r);
      total++; if (r !== 1'b1) begin bad++; $display("FAIL note_rdy[%0d] got=%b want=1", i, r); end
      total++; if (bus.midibyte_nr !== nrs[i]) begin bad++; $display("FAIL note_nr[%0d] got=%h want=%h", i, bus.midibyte_nr, nrs[i]); end
      total++; if (bus.midi_in_data !== bs[i]) begin bad++; $display("FAIL note_data[%0d] got=%h want=%h", i, bus.midi_in_data, bs[i]); end
    end
    total++; if (bus.cur_status !== 8'h90) begin bad++; $display("FAIL note_cur got=%h want=90", bus.cur_status); end
    @(negedge CLOCK_50);
    total++; if (bus.byteready !== 1'b0) begin bad++; $display("FAIL note_pulse_width got=%b want=0", bus.byteready); end
    total++; if (bus.midi_in_data !== 8'h64) begin bad++; $display("FAIL note_data_hold got=%h want=64", bus.midi_in_data); end
  endtask

  task automatic test_running_status();
    logic [7:0] bs [5];
    logic [7:0] nrs [5];
    logic r;
    bs  = '{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h50};
    nrs = '{8'd0, 8'd1, 8'd2, 8'd1, 8'd2};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(bs[i], 1'b0, r);
      total++; if (r !== 1'b1 || bus.midibyte_nr !== nrs[i]) begin
        bad++; $display("FAIL running_nr[%0d] rdy=%b nr=%h want rdy=1 nr=%h", i, r, bus.midibyte_nr, nrs[i]);
      end
    end
    total++; if (bus.cur_status !== 8'h90) begin bad++; $display("FAIL running_cur got=%h want=90", bus.cur_status); end
    total++; if (parse_err_cnt !== 8'h00) begin bad++; $display("FAIL running_err got=%h want=00", parse_err_cnt); end
  endtask

  task automatic test_one_byte_and_realtime();
    logic [7:0] bs [7];
    logic [7:0] nrs [7];
    logic       rdys [7];
    logic [7:0] dat [7];
    logic r;
    bs   = '{8'hC5, 8'h07, 8'h08, 8'h90, 8'h3C, 8'hF8, 8'h64};
    nrs  = '{8'd0, 8'd1, 8'd1, 8'd0, 8'd1, 8'd1, 8'd2};
    rdys = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    dat  = '{8'hC5, 8'h07, 8'h08, 8'h90, 8'h3C, 8'h3C, 8'h64};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      send(bs[i], 1'b0, r);
      total++; if (r !== rdys[i]) begin bad++; $display("FAIL onebyte_rdy[%0d] got=%b want=%b", i, r, rdys[i]); end
      total++; if (bus.midibyte_nr !== nrs[i]) begin bad++; $display("FAIL onebyte_nr[%0d] got=%h want=%h", i, bus.midibyte_nr, nrs[i]); end
      total++; if (bus.midi_in_data !== dat[i]) begin bad++; $display("FAIL onebyte_data[%0d] got=%h want=%h", i, bus.midi_in_data, dat[i]); end
    end
    total++; if (bus.cur_status !== 8'h90) begin bad++; $display("FAIL realtime_cur got=%h want=90", bus.cur_status); end
    total++; if (parse_err_cnt !== 8'h00) begin bad++; $display("FAIL realtime_err got=%h want=00", parse_err_cnt); end
  endtask

  task automatic test_sysex();
    logic [7:0] bs [4];
    logic r;
    bs = '{8'hF0, 8'h7E, 8'h01, 8'hF7};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(bs[i], 1'b0, r);
      total++; if (r !== 1'b1 || bus.midibyte_nr !== 8'(i) || bus.midi_in_data !== bs[i]) begin
        bad++; $display("FAIL sysex[%0d] rdy=%b nr=%h data=%h want rdy=1 nr=%0d data=%h", i, r, bus.midibyte_nr, bus.midi_in_data, i, bs[i]);
      end
      total++; if (bus.cur_status !== 8'hF0) begin bad++; $display("FAIL sysex_cur[%0d] got=%h want=F0", i, bus.cur_status); end
    end
    send(8'h3C, 1'b0, r);
    total++; if (r !== 1'b0) begin bad++; $display("FAIL sysex_after_rdy got=%b want=0", r); end
    total++; if (bus.cur_status !== 8'h00) begin bad++; $display("FAIL sysex_after_cur got=%h want=00", bus.cur_status); end
    total++; if (parse_err_cnt !== 8'd1) begin bad++; $display("FAIL sysex_after_err got=%h want=01", parse_err_cnt); end
  endtask

  task automatic test_sysex_abort_and_stray_eox();
    logic r;
    do_reset();
    send(8'hF7, 1'b0, r);
    total++; if (r !== 1'b0 || parse_err_cnt !== 8'd1) begin bad++; $display("FAIL stray_eox rdy=%b err=%h want rdy=0 err=01", r, parse_err_cnt); end
    send(8'hF0, 1'b0, r);
    send(8'h01, 1'b0, r);
    send(8'h92, 1'b0, r);
    total++; if (r !== 1'b1 || bus.midibyte_nr !== 8'd0 || bus.cur_status !== 8'h92) begin
      bad++; $display("FAIL abort_status rdy=%b nr=%h cur=%h want rdy=1 nr=00 cur=92", r, bus.midibyte_nr, bus.cur_status);
    end
    total++; if (parse_err_cnt !== 8'd2) begin bad++; $display("FAIL abort_err got=%h want=02", parse_err_cnt); end
    send(8'h3C, 1'b0, r);
    total++; if (r !== 1'b1 || bus.midibyte_nr !== 8'd1) begin bad++; $display("FAIL abort_next rdy=%b nr=%h want rdy=1 nr=01", r, bus.midibyte_nr); end
  endtask

  task automatic test_sysex_saturate();
    logic r;
    do_reset();
    send(8'hF0, 1'b0, r);
    for (int i = 0; i < 255; i++) send(8'h11, 1'b0, r);
    total++; if (bus.midibyte_nr !== 8'd255) begin bad++; $display("FAIL sysex_nr_255 got=%h want=FF", bus.midibyte_nr); end
    send(8'h22, 1'b0, r);
    total++; if (r !== 1'b1 || bus.midibyte_nr !== 8'd255 || bus.midi_in_data !== 8'h22) begin
      bad++; $display("FAIL sysex_nr_sat rdy=%b nr=%h data=%h want rdy=1 nr=FF data=22", r, bus.midibyte_nr, bus.midi_in_data);
    end
  endtask

  task automatic test_err_saturate();
    logic r;
    do_reset();
    for (int i = 0; i < 255; i++) send(8'h05, 1'b0, r);
    total++; if (parse_err_cnt !== 8'd255) begin bad++; $display("FAIL err_255 got=%h want=FF", parse_err_cnt); end
    for (int i = 0; i < 3; i++) send(8'h05, 1'b0, r);
    total++; if (parse_err_cnt !== 8'd255) begin bad++; $display("FAIL err_sat got=%h want=FF", parse_err_cnt); end
  endtask

  task automatic test_skip_frame_reset();
    logic [7:0] bs [4];
    logic r;
    bs = '{8'hF2, 8'h10, 8'h20, 8'h3C};
    do_reset();
    send(8'h90, 1'b0, r);
    for (int i = 0; i < 4; i++) begin
      send(bs[i], 1'b0, r);
      total++; if (r !== 1'b0) begin bad++; $display("FAIL skip_rdy[%0d] got=%b want=0", i, r); end
    end
    total++; if (bus.cur_status !== 8'h00 || parse_err_cnt !== 8'd0) begin
      bad++; $display("FAIL skip_state cur=%h err=%h want cur=00 err=00", bus.cur_status, parse_err_cnt);
    end
    send(8'h90, 1'b0, r);
    send(8'h3C, 1'b1, r);
    total++; if (r !== 1'b0 || parse_err_cnt !== 8'd1 || bus.cur_status !== 8'h00) begin
      bad++; $display("FAIL frame_err rdy=%b err=%h cur=%h want rdy=0 err=01 cur=00", r, parse_err_cnt, bus.cur_status);
    end
    send(8'h64, 1'b0, r);
    total++; if (r !== 1'b0 || parse_err_cnt !== 8'd2) begin bad++; $display("FAIL frame_err_idle rdy=%b err=%h want rdy=0 err=02", r, parse_err_cnt); end
    send(8'h90, 1'b0, r);
    send(8'h3C, 1'b0, r);
    #3 reset_reg_N = 1'b0;
    #1;
    total++; if (bus.byteready !== 1'b0 || bus.cur_status !== 8'h00 || bus.midibyte_nr !== 8'h00 ||
                 bus.midi_in_data !== 8'h00 || parse_err_cnt !== 8'h00) begin
      bad++; $display("FAIL async_reset rdy=%b cur=%h nr=%h data=%h err=%h want all 0",
                      bus.byteready, bus.cur_status, bus.midibyte_nr, bus.midi_in_data, parse_err_cnt);
    end
    @(negedge CLOCK_50);
    reset_reg_N = 1'b1;
    send(8'h64, 1'b0, r);
    total++; if (r !== 1'b0 || parse_err_cnt !== 8'd1 || bus.cur_status !== 8'h00) begin
      bad++; $display("FAIL reset_discard rdy=%b err=%h cur=%h want rdy=0 err=01 cur=00", r, parse_err_cnt, bus.cur_status);
    end
  endtask

`ifdef MIDI_ACTIVE_SENSE_EN
  task automatic test_active_sense();
    logic [7:0] exp_d [4];
    logic [7:0] exp_nr [4];
    logic [7:0] exp_cur [4];
    logic [7:0] got_d [4];
    logic [7:0] got_nr [4];
    logic [7:0] got_cur [4];
    logic r;
    logic seen;
    int   n;
    exp_d   = '{8'hB3, 8'h7B, 8'h00, 8'h91};
    exp_nr  = '{8'd0, 8'd1, 8'd2, 8'd0};
    exp_cur = '{8'hB3, 8'hB3, 8'hB3, 8'h91};
    do_reset();
    send(8'hFE, 1'b0, r);
    send(8'h93, 1'b0, r);
    send(8'h3C, 1'b0, r);
    send(8'h64, 1'b0, r);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge CLOCK_50);
      if (as_timeout === 1'b1) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL as_timeout_seen got=0 want=1"); end
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h91;
    n = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge CLOCK_50);
      bus.rx_valid = 1'b0;
      if (bus.byteready === 1'b1 && n < 4) begin
        got_d[n] = bus.midi_in_data; got_nr[n] = bus.midibyte_nr; got_cur[n] = bus.cur_status;
        n++;
      end
    end
    total++; if (n !== 4) begin bad++; $display("FAIL emit_count got=%0d want=4", n); end
    for (int i = 0; i < n; i++) begin
      total++; if (got_d[i] !== exp_d[i] || got_nr[i] !== exp_nr[i] || got_cur[i] !== exp_cur[i]) begin
        bad++; $display("FAIL emit[%0d] data=%h nr=%h cur=%h want data=%h nr=%h cur=%h",
                        i, got_d[i], got_nr[i], got_cur[i], exp_d[i], exp_nr[i], exp_cur[i]);
      end
    end
    total++; if (parse_err_cnt !== 8'd0) begin bad++; $display("FAIL emit_err got=%h want=00", parse_err_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_note_on();
    test_running_status();
    test_one_byte_and_realtime();
    test_sysex();
    test_sysex_abort_and_stray_eox();
    test_sysex_saturate();
    test_err_saturate();
    test_skip_frame_reset();
`ifdef MIDI_ACTIVE_SENSE_EN
    test_active_sense();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
